// File: rtl/system_mem_test_pkg.sv
// Shared types and pattern helpers for the memory test master.
package system_mem_test_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD_REQ,
    RD_WAIT,
    FIN
  } state_t;

  // Galois feedback taps for x^32 + x^22 + x^2 + x + 1
  localparam logic [31:0] LFSR_MASK = 32'h8020_0003;

  // One right-shifting Galois LFSR step
  function automatic logic [31:0] pat_next(input logic [31:0] cur);
    pat_next = cur[0] ? ((cur >> 1) ^ LFSR_MASK) : (cur >> 1);
  endfunction

endpackage

// File: rtl/system_mem_test_pattern_gen.sv
// Pattern register for the memory test master.
// SYSTEM_MEM_TEST_LFSR_EN selects an LFSR sequence; otherwise seed + i.
module system_mem_test_pattern_gen
  import system_mem_test_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load,
  input  logic [31:0] seed,
  input  logic        advance,
  output logic [31:0] pattern
);

  logic [31:0] pattern_q;
  logic [31:0] pattern_d;

  // Next pattern: load has priority over advance
  always_comb begin
    pattern_d = pattern_q;
    if (load) begin
`ifdef SYSTEM_MEM_TEST_LFSR_EN
      pattern_d = (seed == '0) ? 32'h0000_0001 : seed;
`else
      pattern_d = seed;
`endif
    end else if (advance) begin
`ifdef SYSTEM_MEM_TEST_LFSR_EN
      pattern_d = pat_next(pattern_q);
`else
      pattern_d = pattern_q + 32'd1;
`endif
    end
  end

  // Pattern register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pattern_q <= '0;
    else          pattern_q <= pattern_d;
  end

  assign pattern = pattern_q;

endmodule

// File: rtl/system_mem_test_master.sv
// Avalon-MM memory test master: writes a generated pattern over a word
// range, reads it back and counts mismatches.
// Build option: SYSTEM_MEM_TEST_LFSR_EN (LFSR pattern, handled in the
// pattern generator).
module system_mem_test_master
  import system_mem_test_pkg::*;
#(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned ERR_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_count,
  input  logic [31:0]       seed,
  output logic [ADDR_W-1:0] avm_address,
  output logic [3:0]        avm_byteenable,
  output logic              avm_chipselect,
  output logic              avm_write,
  output logic              avm_read,
  output logic [31:0]       avm_writedata,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_waitrequest,
  input  logic              avm_readdatavalid,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [ERR_W-1:0]  err_count,
  output logic [ADDR_W-1:0] first_err_addr
);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    idx_q, idx_d, count_q, count_d, idx_next;
  logic [ADDR_W-1:0]   base_q, base_d, addr_q, addr_d;
  logic [31:0]         seed_q, seed_d;
  logic                write_q, write_d, read_q, read_d, cs_q, cs_d;
  logic                busy_q, busy_d, done_q, done_d, aborted_q, aborted_d;
  logic [ERR_W-1:0]    err_q, err_d;
  logic [ADDR_W-1:0]   first_q, first_d;
  logic                pg_load, pg_adv;
  logic [31:0]         pg_seed, pattern;

  system_mem_test_pattern_gen u_pattern_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (pg_load),
    .seed    (pg_seed),
    .advance (pg_adv),
    .pattern (pattern)
  );

  // FSM next-state, index/address update and read-back checker
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    count_d   = count_q;
    base_d    = base_q;
    addr_d    = addr_q;
    seed_d    = seed_q;
    write_d   = write_q;
    read_d    = read_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    aborted_d = aborted_q;
    err_d     = err_q;
    first_d   = first_q;
    pg_load   = 1'b0;
    pg_adv    = 1'b0;
    pg_seed   = seed_q;
    idx_next  = idx_q + CNT_W'(1);

    case (state_q)
      IDLE: begin
        // done_q high means this is the done cycle of the previous run
        if (start && !done_q) begin
          base_d    = base_addr;
          count_d   = word_count;
          seed_d    = seed;
          pg_seed   = seed;
          pg_load   = 1'b1;
          idx_d     = '0;
          addr_d    = base_addr;
          err_d     = '0;
          first_d   = '0;
          aborted_d = 1'b0;
          busy_d    = 1'b1;
          if (word_count == '0) begin
            state_d = FIN;
          end else begin
            write_d = 1'b1;
            state_d = WR;
          end
        end
      end

      WR: begin
        if (!avm_waitrequest) begin
          if (abort) begin
            write_d   = 1'b0;
            aborted_d = 1'b1;
            state_d   = FIN;
          end else if (idx_next == count_q) begin
            write_d = 1'b0;
            read_d  = 1'b1;
            idx_d   = '0;
            addr_d  = base_q;
            pg_load = 1'b1;
            state_d = RD_REQ;
          end else begin
            idx_d  = idx_next;
            addr_d = base_q + ADDR_W'(idx_next);
            pg_adv = 1'b1;
          end
        end
      end

      RD_REQ: begin
        if (!avm_waitrequest) begin
          read_d  = 1'b0;
          state_d = RD_WAIT;
        end
      end

      RD_WAIT: begin
        if (avm_readdatavalid) begin
          if (avm_readdata != pattern) begin
            if (err_q != '1) err_d = err_q + ERR_W'(1);
            if (err_q == '0) first_d = addr_q;
          end
          if (abort) begin
            aborted_d = 1'b1;
            state_d   = FIN;
          end else if (idx_next == count_q) begin
            state_d = FIN;
          end else begin
            idx_d   = idx_next;
            addr_d  = base_q + ADDR_W'(idx_next);
            pg_adv  = 1'b1;
            read_d  = 1'b1;
            state_d = RD_REQ;
          end
        end
      end

      FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    cs_d = write_d | read_d;
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      count_q   <= '0;
      base_q    <= '0;
      addr_q    <= '0;
      seed_q    <= '0;
      write_q   <= 1'b0;
      read_q    <= 1'b0;
      cs_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      err_q     <= '0;
      first_q   <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      count_q   <= count_d;
      base_q    <= base_d;
      addr_q    <= addr_d;
      seed_q    <= seed_d;
      write_q   <= write_d;
      read_q    <= read_d;
      cs_q      <= cs_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
      err_q     <= err_d;
      first_q   <= first_d;
    end
  end

  assign avm_address    = addr_q;
  assign avm_byteenable = 4'hF;
  assign avm_chipselect = cs_q;
  assign avm_write      = write_q;
  assign avm_read       = read_q;
  assign avm_writedata  = pattern;
  assign busy           = busy_q;
  assign done           = done_q;
  assign aborted        = aborted_q;
  assign err_count      = err_q;
  assign first_err_addr = first_q;

endmodule
